// File: rtl/fdc_sector_buffer_pkg.sv
// Shared types and constants for the FDC sector staging buffer.
package fdc_sector_buffer_pkg;

  localparam int SECTOR_BYTES = 512;
  localparam int PTR_W        = 9;

  typedef enum logic [3:0] {
    IDLE,
    CHECK,
    RD_REQ,
    RD_XFER,
    STREAM_OUT,
    COLLECT_IN,
    WR_REQ,
    WR_XFER,
    FINISH
  } fdc_state_t;

  typedef struct packed {
    logic       write;
    logic [6:0] track;
    logic       side;
    logic [7:0] sector;
  } fdc_req_t;

  // Linear block address of a CHS request (sector numbers are 1-based).
  function automatic logic [31:0] calc_lba(fdc_req_t r, int sides, int spt);
    return (32'(r.track) * 32'(sides) + 32'(r.side)) * 32'(spt)
           + 32'(r.sector) - 32'd1;
  endfunction

endpackage

// File: rtl/fdc_sector_buffer_if.sv
// Request, byte-stream and SD block-image signals of the sector buffer.
interface fdc_sector_buffer_if;

  logic        img_mounted;
  logic [31:0] img_size;

  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [6:0]  req_track;
  logic        req_side;
  logic [7:0]  req_sector;
  logic        busy;
  logic        done;
  logic        err;

  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        rd_ack;
  logic [7:0]  wr_data;
  logic        wr_valid;
  logic        wr_ready;

  logic [31:0] sd_lba;
  logic        sd_rd;
  logic        sd_wr;
  logic        sd_ack;
  logic [8:0]  sd_buff_addr;
  logic [7:0]  sd_buff_dout;
  logic        sd_buff_wr;
  logic [7:0]  sd_buff_din;

  // The sector buffer itself.
  modport slave (
    input  img_mounted, img_size,
    input  req_valid, req_write, req_track, req_side, req_sector,
    output req_ready, busy, done, err,
    output rd_data, rd_valid, wr_ready,
    input  rd_ack, wr_data, wr_valid,
    output sd_lba, sd_rd, sd_wr, sd_buff_din,
    input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr
  );

  // The FDC core / SD host environment.
  modport master (
    output img_mounted, img_size,
    output req_valid, req_write, req_track, req_side, req_sector,
    input  req_ready, busy, done, err,
    input  rd_data, rd_valid, wr_ready,
    output rd_ack, wr_data, wr_valid,
    input  sd_lba, sd_rd, sd_wr, sd_buff_din,
    output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr
  );

endinterface

// File: rtl/fdc_sector_ram.sv
// 512x8 true dual-port sector RAM: port A faces the SD host, port B the FDC.
// Both ports have registered reads; the controller never lets them collide.
module fdc_sector_ram
  import fdc_sector_buffer_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             a_we,
  input  logic [PTR_W-1:0] a_addr,
  input  logic [7:0]       a_wdata,
  output logic [7:0]       a_rdata,
  input  logic             b_we,
  input  logic [PTR_W-1:0] b_addr,
  input  logic [7:0]       b_wdata,
  output logic [7:0]       b_rdata
);

  logic [7:0] mem [SECTOR_BYTES];

  // Array writes from both ports.
  // NOTE: the storage array is never reset (it maps to block RAM); only the
  // read registers below are cleared so the outputs read 0 during reset.
  always_ff @(posedge clk) begin
    if (a_we) mem[a_addr] <= a_wdata;
    if (b_we) mem[b_addr] <= b_wdata;
  end

  // Registered read, SD side.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) a_rdata <= '0;
    else          a_rdata <= mem[a_addr];
  end

  // Registered read, FDC side.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) b_rdata <= '0;
    else          b_rdata <= mem[b_addr];
  end

endmodule

// File: rtl/fdc_sector_buffer.sv
// Sector staging between the SD block-image host and the WD2793 FDC core:
// accepts a CHS request, checks it against the image, moves one sector
// through local RAM and streams it to/from the FDC.
module fdc_sector_buffer
  import fdc_sector_buffer_pkg::*;
#(
  parameter int SPT    = 9,
  parameter int SIDES  = 2,
  parameter int TRACKS = 80
) (
  input logic                 clk,
  input logic                 reset_n,
  fdc_sector_buffer_if.slave  bus
);

  localparam logic [PTR_W-1:0] LAST_BYTE = PTR_W'(SECTOR_BYTES - 1);

  fdc_state_t       state;
  fdc_req_t         req;
  logic [PTR_W-1:0] ptr;

  logic        req_ready_q, busy_q, done_q, err_q;
  logic        rd_valid_q, wr_ready_q, sd_rd_q, sd_wr_q;
  logic [31:0] sd_lba_q;

  logic [31:0] lba_calc;
  logic [40:0] last_addr;
  logic        req_bad;

  logic        a_we, b_we;
  logic [7:0]  b_rdata;

  // LBA and bounds check of the latched request.
  // NOTE: every always_comb output gets a value before any condition, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    lba_calc  = calc_lba(req, SIDES, SPT);
    last_addr = {lba_calc, 9'h1FF};
    req_bad   = !bus.img_mounted
              || (req.sector == 8'd0)
              || (32'(req.sector) > 32'(SPT))
              || (32'(req.track) >= 32'(TRACKS))
              || (last_addr >= {9'd0, bus.img_size});
  end

  // SD bytes land in RAM only while a read transfer is granted; FDC bytes
  // only while the collector is open.
  assign a_we = bus.sd_buff_wr && bus.sd_ack && (state == RD_REQ || state == RD_XFER);
  assign b_we = bus.wr_valid && wr_ready_q;

  fdc_sector_ram u_ram (
    .clk     (clk),
    .reset_n (reset_n),
    .a_we    (a_we),
    .a_addr  (bus.sd_buff_addr),
    .a_wdata (bus.sd_buff_dout),
    .a_rdata (bus.sd_buff_din),
    .b_we    (b_we),
    .b_addr  (ptr),
    .b_wdata (bus.wr_data),
    .b_rdata (b_rdata)
  );

  // Sequencer: request handshake, SD handshakes, byte streaming, abort.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      req         <= '0;
      ptr         <= '0;
      req_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rd_valid_q  <= 1'b0;
      wr_ready_q  <= 1'b0;
      sd_rd_q     <= 1'b0;
      sd_wr_q     <= 1'b0;
      sd_lba_q    <= '0;
    end else begin
      done_q <= 1'b0;
      if (state != IDLE && state != FINISH && !bus.img_mounted) begin
        // Image vanished: drop every request/strobe, FINISH waits out sd_ack.
        sd_rd_q    <= 1'b0;
        sd_wr_q    <= 1'b0;
        rd_valid_q <= 1'b0;
        wr_ready_q <= 1'b0;
        err_q      <= 1'b1;
        state      <= FINISH;
      end else begin
        case (state)
          IDLE: begin
            if (bus.req_valid && req_ready_q) begin
              req         <= '{write:  bus.req_write,  track:  bus.req_track,
                               side:   bus.req_side,   sector: bus.req_sector};
              err_q       <= 1'b0;
              busy_q      <= 1'b1;
              req_ready_q <= 1'b0;
              state       <= CHECK;
            end else begin
              req_ready_q <= 1'b1;
            end
          end
          CHECK: begin
            sd_lba_q <= lba_calc;
            ptr      <= '0;
            if (req_bad) begin
              err_q <= 1'b1;
              state <= FINISH;
            end else if (req.write) begin
              wr_ready_q <= 1'b1;
              state      <= COLLECT_IN;
            end else begin
              sd_rd_q <= 1'b1;
              state   <= RD_REQ;
            end
          end
          RD_REQ: begin
            if (bus.sd_ack) begin
              sd_rd_q <= 1'b0;
              state   <= RD_XFER;
            end
          end
          RD_XFER: begin
            if (!bus.sd_ack) begin
              ptr   <= '0;
              state <= STREAM_OUT;
            end
          end
          STREAM_OUT: begin
            // rd_valid rises one cycle after ptr moves, once RAM data is out.
            if (!rd_valid_q) begin
              rd_valid_q <= 1'b1;
            end else if (bus.rd_ack) begin
              rd_valid_q <= 1'b0;
              if (ptr == LAST_BYTE) begin
                ptr   <= '0;
                state <= FINISH;
              end else begin
                ptr <= ptr + 1'b1;
              end
            end
          end
          COLLECT_IN: begin
            if (b_we) begin
              if (ptr == LAST_BYTE) begin
                ptr        <= '0;
                wr_ready_q <= 1'b0;
                sd_wr_q    <= 1'b1;
                state      <= WR_REQ;
              end else begin
                ptr <= ptr + 1'b1;
              end
            end
          end
          WR_REQ: begin
            if (bus.sd_ack) begin
              sd_wr_q <= 1'b0;
              state   <= WR_XFER;
            end
          end
          WR_XFER: begin
            if (!bus.sd_ack) state <= FINISH;
          end
          FINISH: begin
            if (!bus.sd_ack) begin
              done_q      <= 1'b1;
              busy_q      <= 1'b0;
              req_ready_q <= 1'b1;
              state       <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = b_rdata;
  assign bus.wr_ready  = wr_ready_q;
  assign bus.sd_rd     = sd_rd_q;
  assign bus.sd_wr     = sd_wr_q;
  assign bus.sd_lba    = sd_lba_q;

endmodule

// File: tb/tb_fdc_sector_buffer.sv
// Self-checking bench for fdc_sector_buffer: directed scenarios plus random
// CHS requests, checked against a CHS/image-bounds reference model.
module tb_fdc_sector_buffer;

  localparam int SPT      = 9;
  localparam int SIDES    = 2;
  localparam int TRACKS   = 80;
  localparam int IMG_FULL = 737280;
  localparam int IMG_HALF = 368640;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  fdc_sector_buffer_if bus ();

  fdc_sector_buffer #(.SPT(SPT), .SIDES(SIDES), .TRACKS(TRACKS)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int tests = 0;
  int fails = 0;
  int sd_rd_seen = 0;
  int sd_wr_seen = 0;
  logic [7:0] sd_img   [512];
  logic [7:0] wr_bytes [512];

  always @(posedge clk) begin
    if (bus.sd_rd) sd_rd_seen++;
    if (bus.sd_wr) sd_wr_seen++;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: sector address and legality straight from CHS geometry.
  function automatic logic [31:0] model_lba(int t, int s, int sec);
    return 32'((t * SIDES + s) * SPT + sec - 1);
  endfunction

  function automatic bit model_err(bit mounted, longint size, int t, int s, int sec);
    longint lba;
    if (!mounted || sec < 1 || sec > SPT || t >= TRACKS) return 1'b1;
    lba = longint'((t * SIDES + s) * SPT + sec - 1);
    return (lba * 512 + 511) >= size;
  endfunction

  function automatic logic [31:0] out_flags();
    return 32'({bus.req_ready, bus.busy, bus.done, bus.err,
                bus.rd_valid, bus.wr_ready, bus.sd_rd, bus.sd_wr});
  endfunction

  task automatic idle_inputs();
    bus.req_valid    = 1'b0;
    bus.req_write    = 1'b0;
    bus.req_track    = '0;
    bus.req_side     = 1'b0;
    bus.req_sector   = '0;
    bus.rd_ack       = 1'b0;
    bus.wr_data      = '0;
    bus.wr_valid     = 1'b0;
    bus.sd_ack       = 1'b0;
    bus.sd_buff_addr = '0;
    bus.sd_buff_dout = '0;
    bus.sd_buff_wr   = 1'b0;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    check("reset_flags", out_flags(), 32'd0);
    check("reset_data", {8'd0, bus.rd_data, 8'd0, bus.sd_buff_din}, 32'd0);
    check("reset_lba", bus.sd_lba, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("req_ready_after_reset", 32'(bus.req_ready), 32'd1);
  endtask

  // Called and returns just after a falling edge.
  task automatic send_req(input bit w, input int t, input int s, input int sec);
    int n = 0;
    while (!bus.req_ready && n < 50) begin @(negedge clk); n++; end
    check("req_ready_wait", 32'(bus.req_ready), 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_write  = w;
    bus.req_track  = 7'(t);
    bus.req_side   = 1'(s);
    bus.req_sector = 8'(sec);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("busy_after_accept", 32'(bus.busy), 32'd1);
    check("err_cleared_on_accept", 32'(bus.err), 32'd0);
  endtask

  task automatic wait_done(input bit exp_err, input string tag);
    int n = 0;
    while (!bus.done && n < 100) begin @(negedge clk); n++; end
    check({tag, "_done"}, 32'(bus.done), 32'd1);
    check({tag, "_err"}, 32'(bus.err), 32'(exp_err));
    check({tag, "_idle"}, 32'({bus.busy, bus.req_ready}), 32'b01);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
  endtask

  task automatic fill_sd_img();
    for (int i = 0; i < 512; i++) sd_img[i] = 8'($urandom);
  endtask

  // SD host side of a read; stops after nbytes with sd_ack still high if < 512.
  task automatic sd_read_serve(input logic [31:0] exp_lba, input int nbytes);
    int n = 0;
    while (!bus.sd_rd && n < 100) begin @(negedge clk); n++; end
    check("sd_rd_request", 32'(bus.sd_rd), 32'd1);
    check("sd_lba_read", bus.sd_lba, exp_lba);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    check("sd_rd_held", 32'(bus.sd_rd), 32'd1);
    bus.sd_ack = 1'b1;
    @(negedge clk);
    check("sd_rd_dropped", 32'(bus.sd_rd), 32'd0);
    for (int i = 0; i < nbytes; i++) begin
      bus.sd_buff_addr = 9'(i);
      bus.sd_buff_dout = sd_img[i];
      bus.sd_buff_wr   = 1'b1;
      @(negedge clk);
    end
    bus.sd_buff_wr = 1'b0;
    if (nbytes == 512) begin
      bus.sd_ack = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic stream_bytes(input int nbytes, output int bad);
    int n;
    bad = 0;
    for (int i = 0; i < nbytes; i++) begin
      n = 0;
      while (!bus.rd_valid && n < 20) begin @(negedge clk); n++; end
      if (!bus.rd_valid) begin
        bad = bad + (nbytes - i);
        break;
      end
      if (bus.rd_data !== sd_img[i]) bad++;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      bus.rd_ack = 1'b1;
      @(negedge clk);
      bus.rd_ack = 1'b0;
    end
  endtask

  task automatic collect_write();
    int i = 0;
    int cyc = 0;
    for (int k = 0; k < 512; k++) wr_bytes[k] = 8'($urandom);
    while (i < 512 && cyc < 5000) begin
      cyc++;
      if (bus.wr_ready && $urandom_range(0, 2) != 0) begin
        bus.wr_valid = 1'b1;
        bus.wr_data  = wr_bytes[i];
        @(negedge clk);
        i++;
      end else begin
        // Stray strobes while the collector is closed must be ignored.
        bus.wr_valid = bus.wr_ready ? 1'b0 : 1'($urandom);
        bus.wr_data  = 8'($urandom);
        @(negedge clk);
      end
    end
    bus.wr_valid = 1'b0;
    check("write_bytes_taken", 32'(i), 32'd512);
    check("wr_ready_closed", 32'(bus.wr_ready), 32'd0);
  endtask

  task automatic sd_write_serve(input logic [31:0] exp_lba);
    int n = 0;
    int bad = 0;
    int a;
    while (!bus.sd_wr && n < 100) begin @(negedge clk); n++; end
    check("sd_wr_request", 32'(bus.sd_wr), 32'd1);
    check("sd_lba_write", bus.sd_lba, exp_lba);
    bus.sd_ack = 1'b1;
    @(negedge clk);
    check("sd_wr_dropped", 32'(bus.sd_wr), 32'd0);
    for (int k = 0; k < 512; k++) begin
      a = (k < 256) ? k : $urandom_range(0, 511);
      bus.sd_buff_addr = 9'(a);
      @(negedge clk);
      if (bus.sd_buff_din !== wr_bytes[a]) bad++;
    end
    check("sd_buff_din_readback", 32'(bad), 32'd0);
    bus.sd_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic full_read(input int t, input int s, input int sec, input string tag);
    int bad;
    fill_sd_img();
    send_req(1'b0, t, s, sec);
    sd_read_serve(model_lba(t, s, sec), 512);
    stream_bytes(512, bad);
    check({tag, "_stream"}, 32'(bad), 32'd0);
    wait_done(1'b0, tag);
  endtask

  task automatic full_write(input int t, input int s, input int sec, input string tag);
    send_req(1'b1, t, s, sec);
    collect_write();
    sd_write_serve(model_lba(t, s, sec));
    wait_done(1'b0, tag);
  endtask

  initial begin
    int bad;
    int rd_snap;
    int wr_snap;
    int t;
    int s;
    int sec;
    bit w;
    int bad_secs [2];

    bus.img_mounted = 1'b1;
    bus.img_size    = 32'(IMG_FULL);
    idle_inputs();
    apply_reset();

    // Stray rd_ack while idle changes nothing.
    bus.rd_ack = 1'b1;
    @(negedge clk);
    bus.rd_ack = 1'b0;
    check("stray_rd_ack", out_flags(), 32'h80);

    full_read(0, 0, 1, "read_t0_s0_sec1");
    full_read(79, 1, 9, "read_t79_s1_sec9");

    // Last sector beyond a half-size image.
    bus.img_size = 32'(IMG_HALF);
    rd_snap = sd_rd_seen;
    send_req(1'b0, 79, 1, 9);
    wait_done(model_err(1'b1, IMG_HALF, 79, 1, 9), "half_image");
    check("half_image_no_sd_rd", 32'(sd_rd_seen - rd_snap), 32'd0);
    bus.img_size = 32'(IMG_FULL);

    // Illegal sector numbers: err one cycle after CHECK, done the next.
    bad_secs[0] = 0;
    bad_secs[1] = SPT + 1;
    foreach (bad_secs[k]) begin
      rd_snap = sd_rd_seen;
      send_req(1'b0, 3, 0, bad_secs[k]);
      @(negedge clk);
      check("bad_sector_err_t1", 32'({bus.err, bus.done}), 32'b10);
      @(negedge clk);
      check("bad_sector_done_t2", 32'({bus.err, bus.done}), 32'b11);
      check("bad_sector_no_sd_rd", 32'(sd_rd_seen - rd_snap), 32'd0);
      @(negedge clk);
    end

    full_write(2, 0, 3, "write_t2_s0_sec3");

    // Image removed while byte 100 is presented.
    fill_sd_img();
    send_req(1'b0, 5, 1, 4);
    sd_read_serve(model_lba(5, 1, 4), 512);
    stream_bytes(100, bad);
    check("pre_unmount_stream", 32'(bad), 32'd0);
    while (!bus.rd_valid) @(negedge clk);
    bus.img_mounted = 1'b0;
    @(negedge clk);
    check("unmount_rd_valid_drop", 32'({bus.rd_valid, bus.err}), 32'b01);
    wait_done(1'b1, "unmount");
    bus.img_mounted = 1'b1;

    // Reset in the middle of an SD read transfer.
    fill_sd_img();
    send_req(1'b0, 10, 0, 2);
    sd_read_serve(model_lba(10, 0, 2), 50);
    reset_n = 1'b0;
    #1;
    check("midxfer_reset_flags", out_flags(), 32'd0);
    check("midxfer_reset_lba", bus.sd_lba, 32'd0);
    @(negedge clk);
    apply_reset();
    full_read(10, 0, 2, "after_reset_read");

    // Random requests against the reference model.
    for (int r = 0; r < 5; r++) begin
      t   = $urandom_range(0, 84);
      s   = $urandom_range(0, SIDES - 1);
      sec = $urandom_range(0, SPT + 1);
      w   = 1'($urandom);
      if (model_err(1'b1, IMG_FULL, t, s, sec)) begin
        rd_snap = sd_rd_seen;
        wr_snap = sd_wr_seen;
        send_req(w, t, s, sec);
        wait_done(1'b1, "rand_illegal");
        check("rand_illegal_no_sd", 32'((sd_rd_seen - rd_snap) + (sd_wr_seen - wr_snap)), 32'd0);
      end else if (w) begin
        full_write(t, s, sec, "rand_write");
      end else begin
        full_read(t, s, sec, "rand_read");
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
